// File: rtl/tm_window_counter_if.sv
// Pixel/window/score bundle between the template-matcher front/back end and the SAD stage.
interface tm_window_counter_if #(
    parameter int TW = 50,
    parameter int TH = 80
);
    logic                 ena;
    logic                 d;
    logic [TW*TH-1:0]     win;
    logic [TW*TH-1:0]     diff;
    logic [11:0]          count;
    logic                 win_valid;
    logic                 match;

    modport master (
        output ena, d, diff,
        input  win, count, win_valid, match
    );

    modport slave (
        input  ena, d, diff,
        output win, count, win_valid, match
    );
endinterface

// File: rtl/tm_window_counter.sv
// Line-buffer window generator plus popcount/threshold scorer for the binary template matcher.
module tm_window_counter #(
    parameter int TW     = 50,
    parameter int TH     = 80,
    parameter int IMG_W  = 320,
    parameter int THRESH = 200
) (
    input  logic              clk,
    input  logic              rst,
    tm_window_counter_if.slave bus
);
    localparam int NBITS  = TW * TH;
    localparam int DEPTH  = (TH - 1) * IMG_W + TW;
    localparam int FW     = $clog2(DEPTH + 1);
    localparam int CW     = 12;
    localparam int LVLS   = $clog2(NBITS);
    localparam int LEAVES = 1 << LVLS;
    localparam logic [FW-1:0] DEPTH_F  = FW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

    logic [DEPTH-1:0] stage_reg;
    logic [NBITS-1:0] win_w;
    logic [FW-1:0]    fill_reg;
    logic [FW-1:0]    fill_next;
    logic             win_valid_reg;
    logic             win_valid_next;
    logic [CW-1:0]    count_reg;
    logic             match_reg;
    logic [CW-1:0]    popcount;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_reg <= '0;
        end else if (bus.ena) begin
            stage_reg <= {stage_reg[DEPTH-2:0], bus.d};
        end
    end

    // Row 0 is the oldest line; the newest pixel lands in the bottom-right tap.
    for (genvar gi = 0; gi < TH; gi++) begin : g_row
        for (genvar gj = 0; gj < TW; gj++) begin : g_col
            assign win_w[gi*TW + gj] = stage_reg[(TH-1-gi)*IMG_W + (TW-1-gj)];
        end
    end
    assign bus.win = win_w;

    // Saturating fill counter: once the window is full it stays full until reset.
    always_comb begin
        fill_next = fill_reg;
        if (bus.ena && (fill_reg != DEPTH_F)) begin
            fill_next = fill_reg + 1'b1;
        end
        win_valid_next = (fill_next == DEPTH_F);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_reg      <= '0;
            win_valid_reg <= 1'b0;
        end else begin
            fill_reg      <= fill_next;
            win_valid_reg <= win_valid_next;
        end
    end

    // Balanced adder tree over a power-of-two leaf set; padding leaves are zero.
    for (genvar gl = 0; gl <= LVLS; gl++) begin : lvl
        logic [CW-1:0] node [LEAVES >> gl];
        for (genvar gi = 0; gi < (LEAVES >> gl); gi++) begin : g_node
            if (gl == 0) begin : g_leaf
                if (gi < NBITS) begin : g_bit
                    assign node[gi] = {{(CW-1){1'b0}}, bus.diff[gi]};
                end else begin : g_pad
                    assign node[gi] = '0;
                end
            end else begin : g_sum
                assign node[gi] = lvl[gl-1].node[2*gi] + lvl[gl-1].node[2*gi+1];
            end
        end
    end
    assign popcount = lvl[LVLS].node[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
            match_reg <= 1'b0;
        end else begin
            count_reg <= popcount;
            match_reg <= win_valid_next && (popcount <= THRESH_C);
        end
    end

    assign bus.count     = count_reg;
    assign bus.win_valid = win_valid_reg;
    assign bus.match     = match_reg;
endmodule

// File: tb/tb_tm_window_counter.sv
// Directed bench for tm_window_counter: tap map, enable hold, fill timing, score and reset.
module tb_tm_window_counter;
    localparam int TW     = 50;
    localparam int TH     = 80;
    localparam int IMG_W  = 320;
    localparam int THRESH = 200;
    localparam int NBITS  = TW * TH;
    localparam int DEPTH  = (TH - 1) * IMG_W + TW;

    typedef struct {
        logic [11:0] cnt;
        logic        m;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    logic [NBITS-1:0] ew;
    logic [7:0]       pat;

    always #5 clk = ~clk;

    tm_window_counter_if #(.TW(TW), .TH(TH)) bus ();

    tm_window_counter #(
        .TW(TW), .TH(TH), .IMG_W(IMG_W), .THRESH(THRESH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int hi_idx(input logic [NBITS-1:0] v);
        int h = -1;
        for (int i = 0; i < NBITS; i++) if (v[i] === 1'b1) h = i;
        return h;
    endfunction

    task automatic chk_win(input string tag, input logic [NBITS-1:0] exp);
        logic [NBITS-1:0] obs;
        obs = bus.win;
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d ones (top bit %0d) expected %0d ones (top bit %0d)",
                    tag, $countones(obs), hi_idx(obs), $countones(exp), hi_idx(exp));
        $display("win %s: ones=%0d top=%0d", tag, $countones(obs), hi_idx(obs));
    endtask

    // Drive a diff vector with n ones for one edge; the scoreboard holds the expected score.
    task automatic apply_diff(input int n, input logic exp_valid, input string tag);
        logic [NBITS-1:0] v;
        exp_t e;
        v = '0;
        if (n >= NBITS) v = '1;
        else while ($countones(v) < n) v[$urandom_range(NBITS-1, 0)] = 1'b1;
        bus.diff = v;
        e.cnt = 12'(n);
        e.m   = exp_valid && (n <= THRESH);
        e.tag = tag;
        sb.push_back(e);
        step();
        e = sb.pop_front();
        chk({e.tag, "_count"}, 32'(bus.count), 32'(e.cnt));
        chk({e.tag, "_match"}, 32'(bus.match), 32'(e.m));
        $display("diff %s: ones=%0d count=%0d match=%0b", e.tag, n, bus.count, bus.match);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.ena = 1'b1;
        bus.d   = 1'b1;
        bus.diff = '1;
        repeat (3) step();
        bus.ena = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        bus.ena = 1'b0;
        bus.d = 1'b0;
        bus.diff = '0;

        // Reset state with activity on the inputs.
        do_reset();
        chk_win("reset_win", '0);
        chk("reset_count", 32'(bus.count), 32'd0);
        chk("reset_valid", 32'(bus.win_valid), 32'd0);
        chk("reset_match", 32'(bus.match), 32'd0);

        // Tap map: single white pixel walking through the raster.
        bus.diff = '0;
        bus.ena = 1'b1;
        bus.d = 1'b1;
        step();
        bus.d = 1'b0;
        ew = '0; ew[3999] = 1'b1;
        chk_win("tap_newest", ew);
        repeat (TW - 1) step();
        ew = '0; ew[3950] = 1'b1;
        chk_win("tap_row_left", ew);
        repeat (IMG_W - TW + 1) step();
        ew = '0; ew[3949] = 1'b1;
        chk_win("tap_prev_row_right", ew);
        repeat (TW - 1) step();
        ew = '0; ew[3900] = 1'b1;
        chk_win("tap_prev_row_left", ew);

        // Score before the window is full never matches.
        bus.ena = 1'b0;
        apply_diff(NBITS, 1'b0, "all_ones_invalid");
        apply_diff(0, 1'b0, "zero_invalid");

        // Enable hold, then fill from a clean reset.
        do_reset();
        bus.diff = '0;
        pat = 8'b1011_0010;
        bus.ena = 1'b1;
        for (int j = 7; j >= 0; j--) begin
            bus.d = pat[j];
            step();
        end
        ew = '0;
        for (int j = 0; j < 8; j++) ew[NBITS-1-j] = pat[j];
        chk_win("pattern_loaded", ew);
        bus.ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.d = k[0];
            step();
        end
        chk_win("hold_win", ew);
        chk("hold_valid", 32'(bus.win_valid), 32'd0);

        bus.ena = 1'b1;
        for (int k = 0; k < DEPTH - 8 - 1; k++) begin
            bus.d = 1'($urandom_range(1, 0));
            step();
        end
        chk("fill_before_depth", 32'(bus.win_valid), 32'd0);
        apply_diff(THRESH, 1'b1, "thresh_at_fill");
        chk("fill_at_depth", 32'(bus.win_valid), 32'd1);
        apply_diff(THRESH + 1, 1'b1, "thresh_plus1");
        apply_diff(NBITS, 1'b1, "all_ones_valid");
        apply_diff(17, 1'b1, "small_valid");
        apply_diff(0, 1'b1, "zero_valid");
        repeat (5) step();
        chk("fill_saturates", 32'(bus.win_valid), 32'd1);

        // Asynchronous mid-run reset, checked between clock edges.
        rst = 1'b0;
        #2;
        chk_win("midrst_win", '0);
        chk("midrst_count", 32'(bus.count), 32'd0);
        chk("midrst_valid", 32'(bus.win_valid), 32'd0);
        chk("midrst_match", 32'(bus.match), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.ena = 1'b1;
        bus.d = 1'b1;
        bus.diff = '0;
        repeat (DEPTH - 2) step();
        apply_diff(0, 1'b0, "refill_minus1");
        chk("refill_before_depth", 32'(bus.win_valid), 32'd0);
        apply_diff(0, 1'b1, "refill_at_depth");
        chk("refill_at_depth_valid", 32'(bus.win_valid), 32'd1);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
